fir_data_ring: RTL
==================

# fir_data_ring

Circular-buffer controller that drives the 11-word data BRAM of the FIR engine from the initiator side. Each input sample is written at the ring head. The controller then reads the window back newest-to-oldest as a tap-indexed stream for the MAC datapath. It owns the BRAM port protocol: byte write enables, word-aligned byte addresses, and a one-cycle registered-address read.

## Interface
- TAPS, 11, ring depth in words; also the number of taps streamed per sample.
- DW, 32, sample and BRAM data width.
- AW, 12, BRAM byte-address width.

- axis_clk  in  1  clock.
- axis_rst_n  in  1  synchronous, active-low reset.
- ss_tvalid  in  1  input sample valid.
- ss_tdata  in  DW  input sample.
- ss_tready  out  1  sample accepted when ss_tvalid & ss_tready.
- clear  in  1  request a zero-fill of the ring; sampled in IDLE only.
- out_valid  out  1  tap data valid.
- out_data  out  DW  tap sample; equals data_Do.
- out_tap  out  4  tap index 0..TAPS-1; 0 is the newest sample.
- out_last  out  1  high with out_tap == TAPS-1.
- out_ready  in  1  MAC accepts the tap.
- busy  out  1  high in every state except IDLE.
- data_WE  out  4  BRAM byte write enables.
- data_EN  out  1  BRAM enable.
- data_Di  out  DW  BRAM write data.
- data_A  out  AW  BRAM byte address, always word index << 2.
- data_Do  in  DW  BRAM read data; corresponds to the address presented in the previous cycle; 0 when data_EN = 0.

## Operation
- State registers:
  - state: INIT, IDLE, ISSUE, STREAM.
  - wptr: next write slot, 0..TAPS-1.
  - base: slot of the newest sample.
  - tap: 0..TAPS-1.
  - icnt: zero-fill counter.
- Reset: state = INIT, wptr = base = tap = icnt = 0. While axis_rst_n = 0, every output is 0, including busy and ss_tready.
- INIT: data_EN = 1, data_WE = 4'hF, data_A = icnt << 2, data_Di = 0.
  - icnt increments each cycle.
  - After word TAPS-1: go to IDLE and set wptr = 0.
  - ss_tready = 0 in this state.
- IDLE:
  - ss_tready = ~clear.
  - If clear: go to INIT with icnt = 0. A simultaneous ss_tvalid is not accepted.
  - Else on ss_tvalid: data_EN = 1, data_WE = 4'hF, data_A = wptr << 2, data_Di = ss_tdata; then set base = wptr, advance wptr (TAPS-1 wraps to 0), set tap = 0, go to ISSUE.
  - No handshake: data_EN = 0, data_WE = 0.
- ISSUE: data_EN = 1, data_WE = 0, data_A = slot(0) << 2, out_valid = 0.
  - slot(k) = (base - k) mod TAPS, computed without a divider (conditional add of TAPS).
- STREAM: data_EN = 1, data_WE = 0, out_valid = 1, out_data = data_Do, out_last = (tap == TAPS-1).
  - Address: data_A = slot(tap + hs) << 2, where hs = out_ready & ~out_last. Holding the address during a stall keeps data_Do stable.
  - On a handshake: tap increments.
  - On a handshake with out_last: go to IDLE and set tap = 0.
- clear and ss_tvalid are ignored outside IDLE.
- A reset mid-stream aborts the stream and restarts at INIT; the ring contents are re-zeroed.
- The ring is never full or empty: each sample overwrites the oldest slot, and unwritten slots read as 0.

## Timing
- After reset release: INIT occupies TAPS cycles (11); ss_tready first goes high in cycle 12.
- Sample accepted at edge T:
  - ISSUE is cycle T+1.
  - First out_valid is in cycle T+2.
  - With out_ready held high, taps 0..10 appear in cycles T+2..T+12.
  - IDLE, and ss_tready = 1, in cycle T+13.
  - Minimum sample period: 13 cycles.
- Each out_ready-low cycle extends the stream by one cycle, with out_data, out_tap and data_A stable throughout.
- No BRAM write overlaps a read window.

## Test plan
- Reset, then release:
  - 11 cycles of data_WE = 4'hF with data_A = 0, 4, ..., 40 and data_Di = 0.
  - ss_tready rises in cycle 12.
- Single sample 5, out_ready = 1: out_data = 5, 0, 0, ..., 0 with out_tap 0..10; out_last only on tap 10; written at data_A = 0.
- Samples 1..12, out_ready = 1:
  - The 12th sample is written at data_A = 0 (wrap).
  - Its stream is 12, 11, ..., 2.
- Backpressure: out_ready low for 3 cycles at tap 4 → out_data, out_tap = 4 and data_A are held for 3 cycles; no tap is lost or duplicated.
- clear with ss_tvalid high in IDLE:
  - ss_tready = 0 that cycle and the sample is not accepted.
  - The next sample 7 streams as 7 followed by 10 zeros.
- Reset asserted at tap 6 of a stream → out_valid = 0 at once; INIT re-zeroes the ring; the next sample 3 streams 3 followed by 10 zeros.

Source files
------------

// File: rtl/fir_data_ring.sv
// rtl/fir_data_ring.sv - circular-buffer controller for the FIR engine data BRAM
//
// Writes each accepted input sample at the ring head. It then streams the
// window back newest-to-oldest as tap-indexed words for the MAC datapath.
// After reset, or on request, the whole ring is zero-filled first.
//
// Ports
//   axis_clk, axis_rst_n      clock, synchronous active-low reset
//   ss_tvalid/ss_tdata        input sample stream
//   ss_tready                 sample accepted when ss_tvalid & ss_tready
//   clear                     zero-fill request, honoured in IDLE only
//   out_valid/out_data        tap stream towards the MAC
//   out_tap/out_last          tap index (0 = newest), high on the final tap
//   out_ready                 MAC accepts the current tap
//   busy                      high whenever not IDLE
//   data_WE/EN/Di/A           BRAM port: byte enables, enable, write data, byte address
//   data_Do                   BRAM read data for the address of the previous cycle

module fir_data_ring #(
    parameter int TAPS = 11,
    parameter int DW   = 32,
    parameter int AW   = 12
) (
    input  logic          axis_clk,
    input  logic          axis_rst_n,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    output logic          ss_tready,
    input  logic          clear,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_tap,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic [3:0]    data_WE,
    output logic          data_EN,
    output logic [DW-1:0] data_Di,
    output logic [AW-1:0] data_A,
    input  logic [DW-1:0] data_Do
);

    localparam logic [3:0] LAST = 4'(TAPS - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_STREAM
    } state_t;

    state_t     state, state_n;
    logic [3:0] wptr, wptr_n;
    logic [3:0] base, base_n;
    logic [3:0] tap, tap_n;
    logic [3:0] icnt, icnt_n;
    logic [3:0] word_idx;
    logic       hs;

    // (b - k) mod TAPS for k <= TAPS-1: a single conditional add of TAPS
    // replaces the modulo.
    function automatic logic [3:0] slot(input logic [3:0] b, input logic [3:0] k);
        logic [4:0] d;
        d = {1'b0, b} - {1'b0, k};
        if (d[4]) begin
            d = d + 5'(TAPS);
        end
        return d[3:0];
    endfunction

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state <= S_INIT;
            wptr  <= '0;
            base  <= '0;
            tap   <= '0;
            icnt  <= '0;
        end else begin
            state <= state_n;
            wptr  <= wptr_n;
            base  <= base_n;
            tap   <= tap_n;
            icnt  <= icnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        wptr_n    = wptr;
        base_n    = base;
        tap_n     = tap;
        icnt_n    = icnt;
        ss_tready = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_tap   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        data_WE   = 4'h0;
        data_EN   = 1'b0;
        data_Di   = '0;
        word_idx  = '0;
        hs        = 1'b0;

        unique case (state)
            S_INIT: begin
                busy     = 1'b1;
                data_EN  = 1'b1;
                data_WE  = 4'hF;
                word_idx = icnt;
                icnt_n   = icnt + 4'd1;
                if (icnt == LAST) begin
                    state_n = S_IDLE;
                    wptr_n  = '0;
                    icnt_n  = '0;
                end
            end

            S_IDLE: begin
                // clear wins over a simultaneous sample, so the sample is
                // refused rather than written into a ring that is about to
                // be wiped.
                ss_tready = ~clear;
                if (clear) begin
                    state_n = S_INIT;
                    icnt_n  = '0;
                end else if (ss_tvalid) begin
                    data_EN  = 1'b1;
                    data_WE  = 4'hF;
                    data_Di  = ss_tdata;
                    word_idx = wptr;
                    base_n   = wptr;
                    wptr_n   = (wptr == LAST) ? 4'd0 : wptr + 4'd1;
                    tap_n    = '0;
                    state_n  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Prime the one-cycle read latency with the newest slot.
                busy     = 1'b1;
                data_EN  = 1'b1;
                word_idx = slot(base, 4'd0);
                state_n  = S_STREAM;
            end

            S_STREAM: begin
                busy      = 1'b1;
                data_EN   = 1'b1;
                out_valid = 1'b1;
                out_data  = data_Do;
                out_tap   = tap;
                out_last  = (tap == LAST);
                // Look one slot ahead only when the current tap is consumed.
                // A stall re-presents the same address, so data_Do holds.
                hs        = out_ready & ~out_last;
                word_idx  = slot(base, tap + {3'b000, hs});
                if (out_ready) begin
                    if (out_last) begin
                        state_n = S_IDLE;
                        tap_n   = '0;
                    end else begin
                        tap_n = tap + 4'd1;
                    end
                end
            end

            default: begin
                state_n = S_INIT;
            end
        endcase

        // Reset is synchronous, so the state may still be live during the
        // first reset cycle. All outputs are forced low right away.
        if (!axis_rst_n) begin
            ss_tready = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            out_tap   = '0;
            out_last  = 1'b0;
            busy      = 1'b0;
            data_WE   = 4'h0;
            data_EN   = 1'b0;
            data_Di   = '0;
            word_idx  = '0;
        end
    end

    assign data_A = {{(AW - 6){1'b0}}, word_idx, 2'b00};

endmodule
